// File: rtl/conf_regs_pkg.sv
// Shared configuration package for the sort pipeline: field widths, register map,
// compile-time defaults and the grouped tunable set.
package conf_regs_pkg;

    localparam int unsigned CHANNEL_COUNT = 120;
    localparam int unsigned COE_WIDTH     = 12;
    localparam int unsigned Y_WIDTH       = 11;
    localparam int unsigned TH_WIDTH      = 16;
    localparam int unsigned IV_WIDTH      = 8;
    localparam int unsigned EPOCH_WIDTH   = 8;
    localparam int unsigned QS_WIDTH      = 5;
    localparam int unsigned CH_WIDTH      = $clog2(CHANNEL_COUNT);

    localparam logic [3:0] REG_B0         = 4'd0;
    localparam logic [3:0] REG_B1         = 4'd1;
    localparam logic [3:0] REG_B2         = 4'd2;
    localparam logic [3:0] REG_A0         = 4'd3;
    localparam logic [3:0] REG_A1         = 4'd4;
    localparam logic [3:0] REG_A2         = 4'd5;
    localparam logic [3:0] REG_Q_SCALE    = 4'd6;
    localparam logic [3:0] REG_TIME_TH    = 4'd7;
    localparam logic [3:0] REG_CHANNEL_TH = 4'd8;
    localparam logic [3:0] REG_POS_TH     = 4'd9;
    localparam logic [3:0] REG_INTERVAL   = 4'd10;
    localparam logic [3:0] REG_CTRL       = 4'd11;
    localparam logic [3:0] REG_STATUS     = 4'd12;

    localparam logic [COE_WIDTH-1:0]   COE_B0     = 12'h19E;
    localparam logic [COE_WIDTH-1:0]   COE_B1     = 12'h000;
    localparam logic [COE_WIDTH-1:0]   COE_B2     = 12'hE62;
    localparam logic [COE_WIDTH-1:0]   COE_A0     = 12'h400;
    localparam logic [COE_WIDTH-1:0]   COE_A1     = 12'hB73;
    localparam logic [COE_WIDTH-1:0]   COE_A2     = 12'h0C3;
    localparam logic [QS_WIDTH-1:0]    Q_SCALE    = 5'd10;
    localparam logic [TH_WIDTH-1:0]    TIME_TH    = 16'd12;
    localparam logic [CH_WIDTH-1:0]    CHANNEL_TH = 7'd30;
    localparam logic [2*Y_WIDTH-1:0]   POS_TH     = 22'd1600;
    localparam logic [IV_WIDTH-1:0]    INTERVEL   = 8'd20;

    typedef struct packed {
        logic [5:0][COE_WIDTH-1:0] coe;  // index 0 = B0 ... 5 = A2
        logic [QS_WIDTH-1:0]       q_scale;
        logic [TH_WIDTH-1:0]       time_th;
        logic [CH_WIDTH-1:0]       channel_th;
        logic [2*Y_WIDTH-1:0]      pos_th;
        logic [IV_WIDTH-1:0]       interval;
    } cfg_set_t;

    localparam cfg_set_t CFG_DEFAULT = '{
        coe:        {COE_A2, COE_A1, COE_A0, COE_B2, COE_B1, COE_B0},
        q_scale:    Q_SCALE,
        time_th:    TIME_TH,
        channel_th: CHANNEL_TH,
        pos_th:     POS_TH,
        interval:   INTERVEL
    };

    function automatic logic [31:0] sext_coe(input logic [COE_WIDTH-1:0] c);
        return {{(32 - COE_WIDTH){c[COE_WIDTH-1]}}, c};
    endfunction

endpackage

// File: rtl/conf_field_check.sv
// Combinational legality check for a host write: flags read-only/unmapped
// addresses and out-of-range values that must leave the shadow untouched.
module conf_field_check
    import conf_regs_pkg::*;
(
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic        illegal_o
);

    always_comb begin
        illegal_o = (waddr_i >= REG_STATUS);
        case (waddr_i)
            REG_Q_SCALE:    illegal_o = (wdata_i > 32'(COE_WIDTH - 1));
            REG_CHANNEL_TH: illegal_o = (wdata_i >= 32'(CHANNEL_COUNT));
            default: ;
        endcase
    end

endmodule

// File: rtl/conf_regs.sv
// Runtime configuration registers: host-writable shadow set, atomically copied
// into the active set on a frame boundary or on demand.
module conf_regs
    import conf_regs_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr_valid,
    output logic                   cfg_wr_ready,
    input  logic [3:0]             cfg_waddr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   cfg_rd_en,
    input  logic [3:0]             cfg_raddr,
    output logic [31:0]            cfg_rdata,
    output logic                   cfg_rvalid,
    input  logic                   frame_done_i,
    output logic [6*COE_WIDTH-1:0] coe_o,
    output logic [QS_WIDTH-1:0]    q_scale_o,
    output logic [TH_WIDTH-1:0]    time_th_o,
    output logic [CH_WIDTH-1:0]    channel_th_o,
    output logic [2*Y_WIDTH-1:0]   pos_th_o,
    output logic [IV_WIDTH-1:0]    interval_o,
    output logic                   cfg_pending_o,
    output logic                   cfg_err_o,
    output logic [EPOCH_WIDTH-1:0] cfg_epoch_o
);

    cfg_set_t               shadow_q, shadow_d;
    cfg_set_t               active_q, active_d;
    logic                   pending_q, pending_d;
    logic                   imm_q, imm_d;
    logic                   err_q, err_d;
    logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
    logic                   wr_ready_q;
    logic                   rvalid_q;
    logic [31:0]            rdata_q, rd_val;
    logic                   illegal;
    logic                   wr_fire;
    logic                   apply;

    conf_field_check u_check (
        .waddr_i   (cfg_waddr),
        .wdata_i   (cfg_wdata),
        .illegal_o (illegal)
    );

    assign wr_fire = cfg_wr_valid && wr_ready_q;
    // An immediate commit is latched for one cycle so it applies on the following edge.
    assign apply   = (pending_q && frame_done_i) || imm_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        imm_d     = 1'b0;
        err_d     = err_q;
        epoch_d   = epoch_q;

        if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            epoch_d   = epoch_q + 1'b1;
        end

        if (wr_fire) begin
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                case (cfg_waddr)
                    REG_B0:         shadow_d.coe[0]    = cfg_wdata[COE_WIDTH-1:0];
                    REG_B1:         shadow_d.coe[1]    = cfg_wdata[COE_WIDTH-1:0];
                    REG_B2:         shadow_d.coe[2]    = cfg_wdata[COE_WIDTH-1:0];
                    REG_A0:         shadow_d.coe[3]    = cfg_wdata[COE_WIDTH-1:0];
                    REG_A1:         shadow_d.coe[4]    = cfg_wdata[COE_WIDTH-1:0];
                    REG_A2:         shadow_d.coe[5]    = cfg_wdata[COE_WIDTH-1:0];
                    REG_Q_SCALE:    shadow_d.q_scale    = cfg_wdata[QS_WIDTH-1:0];
                    REG_TIME_TH:    shadow_d.time_th    = cfg_wdata[TH_WIDTH-1:0];
                    REG_CHANNEL_TH: shadow_d.channel_th = cfg_wdata[CH_WIDTH-1:0];
                    REG_POS_TH:     shadow_d.pos_th     = cfg_wdata[2*Y_WIDTH-1:0];
                    REG_INTERVAL:   shadow_d.interval   = cfg_wdata[IV_WIDTH-1:0];
                    REG_CTRL: begin
                        if (cfg_wdata[1]) begin
                            imm_d = 1'b1;
                        end else if (cfg_wdata[0]) begin
                            pending_d = 1'b1;
                        end else begin
                            err_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (cfg_raddr)
            REG_B0:         rd_val = sext_coe(shadow_q.coe[0]);
            REG_B1:         rd_val = sext_coe(shadow_q.coe[1]);
            REG_B2:         rd_val = sext_coe(shadow_q.coe[2]);
            REG_A0:         rd_val = sext_coe(shadow_q.coe[3]);
            REG_A1:         rd_val = sext_coe(shadow_q.coe[4]);
            REG_A2:         rd_val = sext_coe(shadow_q.coe[5]);
            REG_Q_SCALE:    rd_val = 32'(shadow_q.q_scale);
            REG_TIME_TH:    rd_val = 32'(shadow_q.time_th);
            REG_CHANNEL_TH: rd_val = 32'(shadow_q.channel_th);
            REG_POS_TH:     rd_val = 32'(shadow_q.pos_th);
            REG_INTERVAL:   rd_val = 32'(shadow_q.interval);
            REG_STATUS:     rd_val = 32'({epoch_q, err_q, pending_q});
            default:        rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= CFG_DEFAULT;
            active_q   <= CFG_DEFAULT;
            pending_q  <= 1'b0;
            imm_q      <= 1'b0;
            err_q      <= 1'b0;
            epoch_q    <= '0;
            wr_ready_q <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            imm_q      <= imm_d;
            err_q      <= err_d;
            epoch_q    <= epoch_d;
            wr_ready_q <= !pending_d;
            rvalid_q   <= cfg_rd_en;
            if (cfg_rd_en) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign cfg_wr_ready  = wr_ready_q;
    assign cfg_rvalid    = rvalid_q;
    assign cfg_rdata     = rdata_q;
    assign coe_o         = active_q.coe;
    assign q_scale_o     = active_q.q_scale;
    assign time_th_o     = active_q.time_th;
    assign channel_th_o  = active_q.channel_th;
    assign pos_th_o      = active_q.pos_th;
    assign interval_o    = active_q.interval;
    assign cfg_pending_o = pending_q;
    assign cfg_err_o     = err_q;
    assign cfg_epoch_o   = epoch_q;

endmodule

// File: tb/tb_conf_regs.sv
// Self-checking bench for conf_regs: directed scenarios plus randomized traffic
// compared against an array-based model of the register file.
module tb_conf_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr_valid;
    logic        cfg_wr_ready;
    logic [3:0]  cfg_waddr;
    logic [31:0] cfg_wdata;
    logic        cfg_rd_en;
    logic [3:0]  cfg_raddr;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid;
    logic        frame_done_i;
    logic [71:0] coe_o;
    logic [4:0]  q_scale_o;
    logic [15:0] time_th_o;
    logic [6:0]  channel_th_o;
    logic [21:0] pos_th_o;
    logic [7:0]  interval_o;
    logic        cfg_pending_o;
    logic        cfg_err_o;
    logic [7:0]  cfg_epoch_o;

    always #5 clk = ~clk;

    conf_regs dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_wr_valid  (cfg_wr_valid),
        .cfg_wr_ready  (cfg_wr_ready),
        .cfg_waddr     (cfg_waddr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rd_en     (cfg_rd_en),
        .cfg_raddr     (cfg_raddr),
        .cfg_rdata     (cfg_rdata),
        .cfg_rvalid    (cfg_rvalid),
        .frame_done_i  (frame_done_i),
        .coe_o         (coe_o),
        .q_scale_o     (q_scale_o),
        .time_th_o     (time_th_o),
        .channel_th_o  (channel_th_o),
        .pos_th_o      (pos_th_o),
        .interval_o    (interval_o),
        .cfg_pending_o (cfg_pending_o),
        .cfg_err_o     (cfg_err_o),
        .cfg_epoch_o   (cfg_epoch_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: plain per-address arrays of field values.
    int          fw   [11] = '{12, 12, 12, 12, 12, 12, 5, 16, 7, 22, 8};
    logic [31:0] dflt [11] = '{32'h19E, 32'h000, 32'hE62, 32'h400, 32'hB73, 32'h0C3,
                               32'd10, 32'd12, 32'd30, 32'd1600, 32'd20};
    logic [31:0] m_sh [11];
    logic [31:0] m_ac [11];
    bit          m_pend, m_err, m_imm, m_rv;
    int          m_epoch;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int i, input logic [31:0] v);
        return v & ((32'h1 << fw[i]) - 32'h1);
    endfunction

    function automatic logic [31:0] read_val(input int a);
        logic [31:0] v;
        v = 32'h0;
        if (a < 6) begin
            v = m_sh[a];
            if (v[11]) v = v | 32'hFFFF_F000;
        end else if (a <= 10) begin
            v = m_sh[a];
        end else if (a == 12) begin
            v = (32'(m_epoch) << 2) | (32'(m_err) << 1) | 32'(m_pend);
        end
        return v;
    endfunction

    function automatic bit is_illegal(input int a, input logic [31:0] d);
        if (a >= 12) return 1'b1;
        if (a == 8 && d >= 32'd120) return 1'b1;
        if (a == 6 && d > 32'd11) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 11; i++) begin
            m_sh[i] = dflt[i];
            m_ac[i] = dflt[i];
        end
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_imm   = 1'b0;
        m_rv    = 1'b0;
        m_epoch = 0;
        m_rd    = 32'h0;
    endtask

    task automatic check_outputs();
        logic [71:0] ec;
        ec = '0;
        for (int i = 0; i < 6; i++) ec[i*12 +: 12] = m_ac[i][11:0];
        check("coe_o", coe_o, ec);
        check("q_scale_o", 72'(q_scale_o), 72'(m_ac[6]));
        check("time_th_o", 72'(time_th_o), 72'(m_ac[7]));
        check("channel_th_o", 72'(channel_th_o), 72'(m_ac[8]));
        check("pos_th_o", 72'(pos_th_o), 72'(m_ac[9]));
        check("interval_o", 72'(interval_o), 72'(m_ac[10]));
        check("pending", 72'(cfg_pending_o), 72'(m_pend));
        check("err", 72'(cfg_err_o), 72'(m_err));
        check("epoch", 72'(cfg_epoch_o), 72'(m_epoch));
        check("wr_ready", 72'(cfg_wr_ready), 72'(!m_pend));
        check("rvalid", 72'(cfg_rvalid), 72'(m_rv));
        if (m_rv) check("rdata", 72'(cfg_rdata), 72'(m_rd));
    endtask

    // One clock: drive at negedge, advance the model across the edge, check #1 after.
    task automatic step(input bit v, input logic [3:0] wa, input logic [31:0] wd,
                        input bit rd, input logic [3:0] ra, input bit fr);
        logic [31:0] rd_pre;
        bit acc, apply, nimm;
        @(negedge clk);
        cfg_wr_valid = v;
        cfg_waddr    = wa;
        cfg_wdata    = wd;
        cfg_rd_en    = rd;
        cfg_raddr    = ra;
        frame_done_i = fr;

        rd_pre = read_val(int'(ra));
        acc    = v && !m_pend;
        apply  = (m_pend && fr) || m_imm;
        nimm   = 1'b0;
        if (apply) begin
            m_ac    = m_sh;
            m_pend  = 1'b0;
            m_epoch = (m_epoch + 1) % 256;
        end
        if (acc) begin
            if (is_illegal(int'(wa), wd)) begin
                m_err = 1'b1;
            end else if (wa == 4'd11) begin
                if (wd[1]) nimm = 1'b1;
                else if (wd[0]) m_pend = 1'b1;
                else m_err = 1'b0;
            end else begin
                m_sh[wa] = mask(int'(wa), wd);
            end
        end
        m_imm = nimm;
        m_rv  = rd;
        if (rd) m_rd = rd_pre;

        @(posedge clk);
        #1;
        check_outputs();
        cfg_wr_valid = 1'b0;
        cfg_rd_en    = 1'b0;
        frame_done_i = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_data(input logic [3:0] a);
        case (a)
            4'd6:    return $urandom_range(0, 31);
            4'd8:    return $urandom_range(0, 127);
            4'd11:   return $urandom_range(0, 3) | ($urandom & 32'hFFFF_FFF0);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] a;
        rst_n        = 1'b0;
        cfg_wr_valid = 1'b0;
        cfg_waddr    = '0;
        cfg_wdata    = '0;
        cfg_rd_en    = 1'b0;
        cfg_raddr    = '0;
        frame_done_i = 1'b0;
        model_reset();
        #12;
        check("rst_coe", coe_o, 72'h0C3B73400E6200019E);
        check("rst_channel_th", 72'(channel_th_o), 72'd30);
        check("rst_pos_th", 72'(pos_th_o), 72'd1600);
        check("rst_epoch", 72'(cfg_epoch_o), 72'd0);
        check("rst_wr_ready", 72'(cfg_wr_ready), 72'd1);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Frame-boundary commit
        wr(4'd0, 32'h1A0);
        wr(4'd11, 32'd1);
        check("t2_ready_low", 72'(cfg_wr_ready), 72'd0);
        check("t2_b0_hold", 72'(coe_o[11:0]), 72'h19E);
        idle();
        check("t2_b0_hold2", 72'(coe_o[11:0]), 72'h19E);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1);
        check("t2_b0_new", 72'(coe_o[11:0]), 72'h1A0);
        check("t2_epoch", 72'(cfg_epoch_o), 72'd1);
        check("t2_pending", 72'(cfg_pending_o), 72'd0);

        // Illegal channel threshold, then clear err
        wr(4'd8, 32'd120);
        check("t3_err_set", 72'(cfg_err_o), 72'd1);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd8, 1'b0);
        check("t3_readback", 72'(cfg_rdata), 72'd30);
        wr(4'd11, 32'd0);
        check("t3_err_clr", 72'(cfg_err_o), 72'd0);

        // Immediate commit
        wr(4'd10, 32'd7);
        wr(4'd11, 32'd2);
        check("t4_iv_hold", 72'(interval_o), 72'd20);
        idle();
        check("t4_iv_new", 72'(interval_o), 72'd7);
        check("t4_epoch", 72'(cfg_epoch_o), 72'd2);

        // Commit request coinciding with frame_done is not applied
        step(1'b1, 4'd11, 32'd1, 1'b0, 4'd0, 1'b1);
        check("t5_pending", 72'(cfg_pending_o), 72'd1);
        check("t5_epoch_hold", 72'(cfg_epoch_o), 72'd2);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1);
        check("t5_pending_clr", 72'(cfg_pending_o), 72'd0);
        check("t5_epoch", 72'(cfg_epoch_o), 72'd3);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = 4'd11;
            step(1'($urandom_range(0, 1)), a, rand_data(a), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
        end

        // Epoch wrap after 256 immediate commits
        do_reset();
        for (int n = 0; n < 256; n++) wr(4'd11, 32'd2);
        check("t6_epoch_255", 72'(cfg_epoch_o), 72'd255);
        idle();
        check("t6_epoch_wrap", 72'(cfg_epoch_o), 72'd0);

        // Reset while pending discards the commit
        wr(4'd9, 32'd5);
        wr(4'd11, 32'd1);
        check("t6_pending_set", 72'(cfg_pending_o), 72'd1);
        do_reset();
        check("t6_rst_pending", 72'(cfg_pending_o), 72'd0);
        check("t6_rst_pos_th", 72'(pos_th_o), 72'd1600);
        check("t6_rst_ready", 72'(cfg_wr_ready), 72'd1);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 1'b1);
        check("t6_rst_shadow", 72'(cfg_rdata), 72'd1600);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/conf_regs.md
Name: conf_regs

Overview:
- Runtime-programmable successor to the static configuration constants. Holds every tunable of the sort pipeline:
  - biquad filter coefficients B0..A2;
  - Q_SCALE;
  - detection time threshold;
  - channel threshold;
  - position threshold;
  - merge interval.
- Each tunable has a host-writable shadow copy and an active copy.
- Shadow-to-active transfer is atomic, at a frame boundary or on demand, so the downstream filter and cluster stages never see a half-updated set.
- Sits between the host config bus and all pipeline stages; reset values equal the team's compile-time defaults.

Parameters:
- CHANNEL_COUNT, 120, number of recording channels; bounds CHANNEL_TH.
- COE_WIDTH, 12, signed filter coefficient width.
- Y_WIDTH, 11, position coordinate width; POS_TH is 2*Y_WIDTH bits.
- TH_WIDTH, 16, time threshold width.
- IV_WIDTH, 8, merge interval width.
- EPOCH_WIDTH, 8, commit counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_wr_valid  in  1  write request.
- cfg_wr_ready  out  1  write accept.
- cfg_waddr  in  4  write register index.
- cfg_wdata  in  32  write data, LSB-aligned.
- cfg_rd_en  in  1  read strobe.
- cfg_raddr  in  4  read register index.
- cfg_rdata  out  32  read data.
- cfg_rvalid  out  1  read data valid.
- frame_done_i  in  1  one-cycle pulse after the last channel of a sample frame.
- coe_o  out  6*COE_WIDTH  active {A2,A1,A0,B2,B1,B0}, B0 in the LSBs.
- q_scale_o  out  5  active Q scale.
- time_th_o  out  TH_WIDTH  active time threshold.
- channel_th_o  out  $clog2(CHANNEL_COUNT)  active channel threshold.
- pos_th_o  out  2*Y_WIDTH  active position threshold.
- interval_o  out  IV_WIDTH  active merge interval.
- cfg_pending_o  out  1  commit armed, not yet applied.
- cfg_err_o  out  1  sticky illegal-access flag.
- cfg_epoch_o  out  EPOCH_WIDTH  count of applied commits.

Behaviour:
- Register map:
  - 0-5: B0, B1, B2, A0, A1, A2.
  - 6: Q_SCALE.
  - 7: TIME_TH.
  - 8: CHANNEL_TH.
  - 9: POS_TH.
  - 10: INTERVAL.
  - 11: CTRL, write-only. bit0 = commit on frame, bit1 = commit immediate.
  - 12: STATUS, read-only. {cfg_epoch, cfg_err, cfg_pending} in bits [EPOCH_WIDTH+1:0].
  - 13-15: unmapped.
- Reset values, shadow and active copies alike:
  - B0=0x19E, B1=0x000, B2=0xE62, A0=0x400, A1=0xB73, A2=0x0C3.
  - Q_SCALE=10, TIME_TH=12, CHANNEL_TH=30, POS_TH=1600, INTERVAL=20.
- Reset values of status and bus outputs: pending=0, err=0, epoch=0, cfg_rvalid=0, cfg_rdata=0, cfg_wr_ready=1.
- Write handshake:
  - A transfer occurs on a rising edge with cfg_wr_valid && cfg_wr_ready.
  - cfg_wr_ready is registered and equals !pending, so the shadow set is frozen from commit request until apply.
  - Data is truncated to the field width. Coefficients take the low COE_WIDTH bits as two's complement.
- Rejected writes: the transfer completes, the shadow is unchanged, and cfg_err is set.
  - Writes to address 12-15.
  - CHANNEL_TH write value >= CHANNEL_COUNT.
  - Q_SCALE write value > COE_WIDTH-1.
- CTRL writes:
  - bit0=1 → pending=1 on the next edge.
  - bit1=1 → apply on the next edge without waiting for a frame; bit1 dominates if both are set.
  - CTRL write with bits[1:0]=0 → clears cfg_err. This is the only way to clear cfg_err.
- Apply event: on the edge where (pending && frame_done_i), or the edge following an immediate commit:
  - active <= shadow for all fields in the same edge;
  - pending <= 0;
  - epoch <= epoch+1, wrapping modulo 2^EPOCH_WIDTH.
- frame_done_i while not pending → no effect.
- frame_done_i in the same cycle the commit CTRL write is accepted → not applied. The block waits for the next frame_done_i.
- Active outputs are driven directly from the active registers; new values appear the cycle after the apply edge.
- Reads:
  - cfg_rd_en samples cfg_raddr; cfg_rdata and cfg_rvalid are valid the next cycle for one cycle.
  - Addresses 0-10 return the shadow value, sign-extended for coefficients.
  - Address 12 returns STATUS.
  - Addresses 11 and 13-15 return 0 and do not set err.
- Simultaneous read and write to the same address → read returns the pre-write value.
- Reset asserted mid-pending → every register returns to its default and the pending commit is discarded.

Decomposition:
- Add to the shared config package:
  - register index constants (REG_B0..REG_STATUS);
  - reset-default constants, equal to the existing COE_*, TIME_TH, CHANNEL_TH, POS_TH and INTERVEL values;
  - a packed cfg_set_t struct grouping all tunable fields.
- Shadow and active are both cfg_set_t, which makes the apply a single assignment.
- One sub-module is natural: conf_field_check, a combinational legality check per address/data.

Test Plan:
1. Reset → coe_o reads {0x0C3,0xB73,0x400,0xE62,0x000,0x19E}, channel_th_o=30, pos_th_o=1600, epoch=0, cfg_wr_ready=1.
2. Write B0=0x1A0, then CTRL=1, then frame_done_i two cycles later:
   - cfg_wr_ready=0 while pending;
   - coe_o[11:0] remains 0x19E until the apply edge, then reads 0x1A0;
   - epoch=1, pending=0.
3. Write CHANNEL_TH=120 → shadow stays 30 on readback, cfg_err=1; CTRL=0 → cfg_err=0.
4. Write INTERVAL=7, CTRL=2 with no frame_done_i → interval_o=7 two cycles after the CTRL write; epoch increments.
5. CTRL=1 accepted in the same cycle as frame_done_i → no apply; the next frame_done_i applies.
6. 256 immediate commits → epoch wraps to 0. Reset asserted while pending → defaults restored, pending=0.
